strand_issue_scheduler: RTL

Per-core round-robin scheduler choosing which strand issues into the pipeline each cycle. It sits between the strand fetch/select front end and decode. Eligibility comes from the control-register strand enable mask, per-strand instruction-ready flags, and a suspend state it tracks for strands waiting on long-latency memory operations. The registered grant drives instruction selection for the next cycle.

---
 rtl/strand_issue_scheduler_pkg.sv | 12 +
 rtl/strand_issue_scheduler_if.sv | 34 +++
 rtl/strand_issue_scheduler_rr_arbiter.sv | 34 +++
 rtl/strand_issue_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/strand_issue_scheduler_pkg.sv
// Shared strand-count defines for the strand issue scheduler.
// Contents:
//   STRANDS_PER_CORE    - number of hardware strands per core
//   STRAND_INDEX_WIDTH  - width of a strand index
//   QUANTUM_CNT_WIDTH   - width of the issue-quantum counter (SCHED_QUANTUM_EN builds)
package strand_issue_scheduler_pkg;

  localparam int unsigned STRANDS_PER_CORE   = 4;
  localparam int unsigned STRAND_INDEX_WIDTH = 2;
  localparam int unsigned QUANTUM_CNT_WIDTH  = 4;

endpackage

// File: rtl/strand_issue_scheduler_if.sv
// Interface bundling the scheduler's front-end, pipeline and issue signals.
// Signals:
//   cr_strand_enable    - strand enable mask from control registers
//   if_strand_ready     - per-strand decoded-ready flags
//   ex_stall            - pipeline cannot accept an issue
//   rb_suspend_strand   - strand blocked on a cache miss (one-hot or zero)
//   l2_resume_strand    - miss satisfied, strand runnable again
//   ss_issue_valid      - registered grant valid
//   ss_issue_strand     - registered granted strand index
//   ss_strand_suspended - registered suspend state
// Modports: master (front end / environment), slave (scheduler).
interface strand_issue_scheduler_if;
  import strand_issue_scheduler_pkg::*;

  logic [STRANDS_PER_CORE-1:0]   cr_strand_enable;
  logic [STRANDS_PER_CORE-1:0]   if_strand_ready;
  logic                          ex_stall;
  logic [STRANDS_PER_CORE-1:0]   rb_suspend_strand;
  logic [STRANDS_PER_CORE-1:0]   l2_resume_strand;
  logic                          ss_issue_valid;
  logic [STRAND_INDEX_WIDTH-1:0] ss_issue_strand;
  logic [STRANDS_PER_CORE-1:0]   ss_strand_suspended;

  modport master (
    output cr_strand_enable, if_strand_ready, ex_stall, rb_suspend_strand, l2_resume_strand,
    input  ss_issue_valid, ss_issue_strand, ss_strand_suspended
  );

  modport slave (
    input  cr_strand_enable, if_strand_ready, ex_stall, rb_suspend_strand, l2_resume_strand,
    output ss_issue_valid, ss_issue_strand, ss_strand_suspended
  );

endinterface

// File: rtl/strand_issue_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, generic in width.
// Ports:
//   req        - request vector
//   last_grant - index of the previous winner; search starts just after it
//   grant      - index of the winner (equals last_grant when nothing requests)
//   valid      - at least one request present
module rr_arbiter #(
  parameter int unsigned Width    = 4,
  parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    req,
  input  logic [IdxWidth-1:0] last_grant,
  output logic [IdxWidth-1:0] grant,
  output logic                valid
);

  logic [IdxWidth-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_grant is the final one written.
  always_comb begin
    grant = last_grant;
    valid = 1'b0;
    cand  = last_grant;
    for (int off = int'(Width); off > 0; off--) begin
      cand = IdxWidth'((int'(last_grant) + off) % int'(Width));
      if (req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/strand_issue_scheduler.sv
// strand_issue_scheduler: per-core round-robin choice of the strand that
// issues into the pipeline next cycle. Tracks per-strand suspend state for
// long-latency misses and registers the grant.
// Ports:
//   clk   - core clock
//   reset - asynchronous active-high reset
//   sched - strand_issue_scheduler_if.slave (enable/ready/stall/suspend/resume
//           in, registered grant and suspend state out)
// Parameters:
//   QUANTUM - max consecutive consumed issues per grant (1..15), used only
//             when the macro SCHED_QUANTUM_EN is defined; otherwise the
//             scheduler rotates after every consumed issue.
module strand_issue_scheduler
  import strand_issue_scheduler_pkg::*;
#(
  parameter int unsigned QUANTUM = 4
) (
  input logic                     clk,
  input logic                     reset,
  strand_issue_scheduler_if.slave sched
);

  if (QUANTUM < 1 || QUANTUM > 15) begin : gen_quantum_range
    $error("QUANTUM must be in 1..15");
  end

  logic [STRANDS_PER_CORE-1:0]   suspended_q, suspended_d, eligible;
  logic                          valid_q, valid_d;
  logic [STRAND_INDEX_WIDTH-1:0] strand_q, strand_d, last_q, last_d;
  logic [STRAND_INDEX_WIDTH-1:0] arb_last, arb_grant;
  logic                          arb_valid, consumed, keep;

  always_comb begin
    // Resume beats a same-cycle suspend.
    suspended_d = (suspended_q | sched.rb_suspend_strand) & ~sched.l2_resume_strand;
    eligible    = sched.cr_strand_enable & sched.if_strand_ready & ~suspended_d;
    consumed    = valid_q & ~sched.ex_stall;
    // A consumed issue moves the pointer, so search from the strand just issued.
    arb_last    = consumed ? strand_q : last_q;
  end

  rr_arbiter #(
    .Width    (STRANDS_PER_CORE),
    .IdxWidth (STRAND_INDEX_WIDTH)
  ) u_rr_arbiter (
    .req        (eligible),
    .last_grant (arb_last),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

`ifdef SCHED_QUANTUM_EN
  localparam logic [QUANTUM_CNT_WIDTH-1:0] QuantumLast = QUANTUM_CNT_WIDTH'(QUANTUM - 1);

  logic [QUANTUM_CNT_WIDTH-1:0] quantum_q, quantum_d;

  // Stay on the granted strand until it has issued QUANTUM times in a row.
  assign keep = consumed & eligible[strand_q] & (quantum_q < QuantumLast);

  always_comb begin
    if (sched.ex_stall && valid_d) begin
      quantum_d = quantum_q;
    end else if (keep) begin
      quantum_d = quantum_q + 1'b1;
    end else begin
      quantum_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quantum_q <= '0;
    end else begin
      quantum_q <= quantum_d;
    end
  end
`else
  assign keep = 1'b0;
`endif

  always_comb begin
    valid_d  = valid_q;
    strand_d = strand_q;
    last_d   = consumed ? strand_q : last_q;
    if (valid_q && !sched.cr_strand_enable[strand_q]) begin
      // A disabled strand loses its grant at once, even if others are eligible.
      valid_d = 1'b0;
    end else if (sched.ex_stall) begin
      if (valid_q && !eligible[strand_q]) begin
        valid_d = 1'b0;
      end
    end else if (!keep) begin
      valid_d = arb_valid;
      if (arb_valid) begin
        strand_d = arb_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      suspended_q <= '0;
      valid_q     <= 1'b0;
      strand_q    <= '0;
      last_q      <= STRAND_INDEX_WIDTH'(STRANDS_PER_CORE - 1);
    end else begin
      suspended_q <= suspended_d;
      valid_q     <= valid_d;
      strand_q    <= strand_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    sched.ss_issue_valid      = valid_q;
    sched.ss_issue_strand     = strand_q;
    sched.ss_strand_suspended = suspended_q;
  end

endmodule
